// File: rtl/aes_enc_round_engine.sv
// aes_enc_round_engine: iterative AES-128 encryption, one round per clock,
// round keys fetched by index from an external combinational key store.
module aes_enc_round_engine (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         start,
   input  logic [0:127] text_in,
   output logic [3:0]   key_idx,
   input  logic [0:127] round_key,
   output logic         busy,
   output logic         done,
   output logic [0:127] text_out
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   fsm_e         fsm_q, fsm_d;
   logic [3:0]   cnt_q, cnt_d, key_idx_q, key_idx_d;
   logic [0:127] state_q, state_d, text_out_q, text_out_d, rnd;
   logic         busy_q, busy_d, done_q, done_d;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes, ShiftRows and (unless final round) MixColumns; key added by caller
   function automatic logic [0:127] round_f(input logic [0:127] s, input logic mix);
      logic [0:127] sb, sr, mc;
      logic [7:0]   a0, a1, a2, a3;
      for (int i = 0; i < 16; i++) sb[8*i +: 8] = SBOX[{s[8*i +: 8], 3'b000} +: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[32*c +: 8];
         a1 = sr[32*c+8 +: 8];
         a2 = sr[32*c+16 +: 8];
         a3 = sr[32*c+24 +: 8];
         mc[32*c +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return mix ? mc : sr;
   endfunction

   always_comb begin
      fsm_d      = fsm_q;
      cnt_d      = cnt_q;
      state_d    = state_q;
      text_out_d = text_out_q;
      rnd        = round_f(state_q, cnt_q != 4'd10) ^ round_key;
      if (fsm_q != RUN) begin
         fsm_d = start ? RUN : IDLE;
         if (start) begin
            state_d = text_in ^ round_key;
            cnt_d   = 4'd1;
         end
      end else if (cnt_q == 4'd10) begin
         text_out_d = rnd;
         fsm_d      = DONE;
      end else begin
         state_d = rnd;
         cnt_d   = cnt_q + 4'd1;
      end
      busy_d    = fsm_d == RUN;
      done_d    = fsm_d == DONE;
      key_idx_d = (fsm_d == RUN) ? cnt_d : 4'd0;
   end

   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         fsm_q      <= IDLE;
         cnt_q      <= '0;
         state_q    <= '0;
         text_out_q <= '0;
         key_idx_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         text_out_q <= text_out_d;
         key_idx_q  <= key_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end

   assign key_idx  = key_idx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign text_out = text_out_q;
endmodule
